// File: rtl/alu_uart_if.sv
// Sequences three UART bytes (A, B, opcode) into an external ALU and sends the result back.
// Define ALU_UART_IF_OVF_BYTE_EN to also transmit the captured overflow flag as a second byte.
module alu_uart_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_overflow,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy
);

`ifdef ALU_UART_IF_OVF_BYTE_EN
  typedef enum logic [2:0] {
    GET_A    = 3'd0,
    GET_B    = 3'd1,
    GET_OP   = 3'd2,
    LOAD     = 3'd3,
    SEND     = 3'd4,
    WAIT_TX  = 3'd5,
    SEND_OVF = 3'd6,
    WAIT_OVF = 3'd7
  } state_t;
`else
  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    LOAD    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;

`ifdef ALU_UART_IF_OVF_BYTE_EN
  logic               ovf_q, ovf_d;
`else
  logic               ovf_unused;
  assign ovf_unused = i_alu_overflow;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= GET_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef ALU_UART_IF_OVF_BYTE_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
`ifdef ALU_UART_IF_OVF_BYTE_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
`ifdef ALU_UART_IF_OVF_BYTE_EN
    ovf_d      = ovf_q;
`endif
    case (state_q)
      GET_A: if (i_rx_done) begin
        alu_a_d = i_rx_data;
        state_d = GET_B;
      end
      GET_B: if (i_rx_done) begin
        alu_b_d = i_rx_data;
        state_d = GET_OP;
      end
      GET_OP: if (i_rx_done) begin
        alu_op_d = i_rx_data[NB_OP-1:0];
        state_d  = LOAD;
      end
      // One idle cycle so the ALU sees the freshly registered opcode.
      LOAD: state_d = SEND;
      SEND: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
`ifdef ALU_UART_IF_OVF_BYTE_EN
        ovf_d      = i_alu_overflow;
`endif
        state_d    = WAIT_TX;
      end
`ifdef ALU_UART_IF_OVF_BYTE_EN
      WAIT_TX: if (i_tx_done) state_d = SEND_OVF;
      SEND_OVF: begin
        tx_data_d  = {{(NB_DATA-1){1'b0}}, ovf_q};
        tx_start_d = 1'b1;
        state_d    = WAIT_OVF;
      end
      WAIT_OVF: if (i_tx_done) state_d = GET_A;
`else
      WAIT_TX: if (i_tx_done) state_d = GET_A;
`endif
      default: state_d = GET_A;
    endcase
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q != GET_A);

endmodule

// File: tb/tb_alu_uart_if.sv
// Self-checking bench for alu_uart_if: table vectors, random transactions and corner sequences.
// Honours ALU_UART_IF_OVF_BYTE_EN to expect the extra overflow byte.
module tb_alu_uart_if;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_alu_overflow;
  logic [NB_DATA-1:0] o_alu_a, o_alu_b, o_tx_data;
  logic [NB_OP-1:0]   o_alu_op;
  logic               o_tx_start, o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_uart_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_tx_done(i_tx_done), .i_alu_result(i_alu_result), .i_alu_overflow(i_alu_overflow),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_tx_data(o_tx_data),
    .o_tx_start(o_tx_start), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural ALU: returns {overflow, result}
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [7:0] r;
    logic       v;
    r = 8'h00;
    v = 1'b0;
    case (op)
      6'h20: begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      6'h22: begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = a >> b[2:0];
      6'h03: r = 8'($signed(a) >>> b[2:0]);
      default: r = 8'h00;
    endcase
    return {v, r};
  endfunction

  always_comb {i_alu_overflow, i_alu_result} = alu_ref(o_alu_a, o_alu_b, o_alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clk); #1;
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    i_tx_done = 1'b1;
    @(posedge i_clk); #1;
    i_tx_done = 1'b0;
  endtask

  // Sends the opcode byte (A and B already sent) and checks the whole response.
  task automatic finish_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] opb, input logic [7:0] exp_tx, input logic exp_ovf,
                            input bit junk_load, input bit junk_wait);
    logic [5:0] exp_op;
    exp_op = opb[5:0];
    send_byte(opb);
    chk({tag, " op"}, 32'(o_alu_op), 32'(exp_op));
    chk({tag, " a"}, 32'(o_alu_a), 32'(a));
    chk({tag, " b"}, 32'(o_alu_b), 32'(b));
    if (junk_load) begin
      i_rx_data = 8'h55;
      i_rx_done = 1'b1;
    end
    @(posedge i_clk); #1;
    chk({tag, " early start"}, 32'(o_tx_start), 32'd0);
    chk({tag, " busy"}, 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    i_rx_done = 1'b0;
    chk({tag, " start"}, 32'(o_tx_start), 32'd1);
    chk({tag, " tx_data"}, 32'(o_tx_data), 32'(exp_tx));
    chk({tag, " a held"}, 32'(o_alu_a), 32'(a));
    chk({tag, " b held"}, 32'(o_alu_b), 32'(b));
    chk({tag, " op held"}, 32'(o_alu_op), 32'(exp_op));
    @(posedge i_clk); #1;
    chk({tag, " start width"}, 32'(o_tx_start), 32'd0);
    if (junk_wait) begin
      send_byte(8'hAA);
      chk({tag, " a after wait rx"}, 32'(o_alu_a), 32'(a));
      chk({tag, " busy in wait"}, 32'(o_busy), 32'd1);
    end
    @(posedge i_clk); #1;
    chk({tag, " no extra start"}, 32'(o_tx_start), 32'd0);
    pulse_tx_done();
`ifdef ALU_UART_IF_OVF_BYTE_EN
    chk({tag, " busy ovf"}, 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    chk({tag, " ovf start"}, 32'(o_tx_start), 32'd1);
    chk({tag, " ovf byte"}, 32'(o_tx_data), {31'd0, exp_ovf});
    @(posedge i_clk); #1;
    chk({tag, " ovf start width"}, 32'(o_tx_start), 32'd0);
    pulse_tx_done();
`endif
    chk({tag, " idle"}, 32'(o_busy), 32'd0);
    $display("txn %s: a=%02h b=%02h op=%02h tx=%02h ovf=%0d", tag, a, b, opb, o_tx_data, exp_ovf);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] opb, input logic [7:0] exp_tx, input logic exp_ovf,
                         input bit junk_load, input bit junk_wait);
    send_byte(a);
    send_byte(b);
    finish_txn(tag, a, b, opb, exp_tx, exp_ovf, junk_load, junk_wait);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [7:0] tx;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];
  int   ops[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra, rb, rop;
    logic [8:0] exp;

    vecs[0] = '{a: 8'h05, b: 8'h03, opb: 8'h20, tx: 8'h08, ovf: 1'b0};
    vecs[1] = '{a: 8'hF0, b: 8'h0F, opb: 8'hE4, tx: 8'h00, ovf: 1'b0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, opb: 8'h20, tx: 8'h80, ovf: 1'b1};
    vecs[3] = '{a: 8'h0A, b: 8'h03, opb: 8'h22, tx: 8'h07, ovf: 1'b0};
    vecs[4] = '{a: 8'h0C, b: 8'h0A, opb: 8'h65, tx: 8'h0E, ovf: 1'b0};
    vecs[5] = '{a: 8'hF0, b: 8'h0F, opb: 8'h26, tx: 8'hFF, ovf: 1'b0};
    ops = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h26, 32'h27, 32'h02, 32'h03};

    i_rst_n   = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    #12;
    chk("reset a", 32'(o_alu_a), 32'd0);
    chk("reset b", 32'(o_alu_b), 32'd0);
    chk("reset op", 32'(o_alu_op), 32'd0);
    chk("reset tx_data", 32'(o_tx_data), 32'd0);
    chk("reset start", 32'(o_tx_start), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    for (int i = 0; i < 6; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].opb, vecs[i].tx, vecs[i].ovf, 1'b0, 1'b0);

    // Bytes arriving in LOAD/SEND are dropped
    run_txn("rx_in_load", 8'h21, 8'h12, 8'h20, 8'h33, 1'b0, 1'b1, 1'b0);

    // Byte arriving in WAIT_TX is dropped; the next three form a clean transaction
    run_txn("rx_in_wait", 8'h11, 8'h22, 8'h25, 8'h33, 1'b0, 1'b0, 1'b1);
    run_txn("after_wait", 8'h40, 8'h30, 8'h22, 8'h10, 1'b0, 1'b0, 1'b0);

    // tx_done in GET_A / GET_B must be ignored
    pulse_tx_done();
    repeat (2) begin
      chk("txdone getA busy", 32'(o_busy), 32'd0);
      chk("txdone getA start", 32'(o_tx_start), 32'd0);
      @(posedge i_clk); #1;
    end
    send_byte(8'h09);
    pulse_tx_done();
    chk("txdone getB busy", 32'(o_busy), 32'd1);
    chk("txdone getB start", 32'(o_tx_start), 32'd0);
    send_byte(8'h04);
    chk("txdone getB a", 32'(o_alu_a), 32'h09);
    finish_txn("txdone_ignored", 8'h09, 8'h04, 8'h22, 8'h05, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset after the B byte
    send_byte(8'h33);
    send_byte(8'h44);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("async rst a", 32'(o_alu_a), 32'd0);
    chk("async rst b", 32'(o_alu_b), 32'd0);
    chk("async rst op", 32'(o_alu_op), 32'd0);
    chk("async rst tx_data", 32'(o_tx_data), 32'd0);
    chk("async rst start", 32'(o_tx_start), 32'd0);
    chk("async rst busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    run_txn("post_reset", 8'h02, 8'h02, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0);

    // Random transactions against the behavioural model
    for (int i = 0; i < 24; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = {2'($urandom), 6'(ops[$urandom_range(7)])};
      exp = alu_ref(ra, rb, rop[5:0]);
      run_txn($sformatf("rnd%0d", i), ra, rb, rop, exp[7:0], exp[8],
              1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
